// File: rtl/key_sw_input_ctrl.sv
// key_sw_input_ctrl: synchronizes, debounces and latches KEY/SW pins behind a memory-mapped read port.
// Define KEY_AUTOREPEAT_EN to add per-key auto-repeat press events while a key is held.
module key_sw_input_ctrl #(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_BITS        = 16,
`ifdef KEY_AUTOREPEAT_EN
    parameter int REPEAT_CYCLES   = 5000000,
`endif
    parameter logic [DBITS-1:0] ADDR_KEY     = 'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW      = 'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KEYSTAT = 'hF0000018
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] memAddr,
    input  logic             memWrEn,
    input  logic [DBITS-1:0] memWrData,
    output logic             rdHit,
    output logic [DBITS-1:0] rdData,
    output logic [3:0]       keyLevel,
    output logic [9:0]       swLevel,
    output logic             keyIrq
);
    logic [3:0] key_s1, key_s2, sticky, ovr, evt, clr_s, clr_o, sticky_n, ovr_n;
    logic [9:0] sw_s1, sw_s2;
    logic [13:0] din, stab, hit;
    logic [CNT_BITS-1:0] cnt [14];
    logic wr_stat, unused_wr;

    // keys and switches share one debounce array: bits [3:0] keys (1 = pressed), [13:4] switches
    assign din  = {sw_s2, ~key_s2};
    assign stab = {swLevel, keyLevel};

    for (genvar i = 0; i < 14; i++) begin : g_db
        assign hit[i] = din[i] != stab[i] && cnt[i] == CNT_BITS'(DEBOUNCE_CYCLES - 1);
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RBITS = $clog2(REPEAT_CYCLES + 1);
    logic [RBITS-1:0] rcnt [4];
    logic [3:0] rep;
    for (genvar i = 0; i < 4; i++) begin : g_rep
        assign rep[i] = keyLevel[i] && rcnt[i] == RBITS'(REPEAT_CYCLES - 1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) rcnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) rcnt[k] <= keyLevel[k] && !rep[k] ? rcnt[k] + 1'b1 : '0;
        end
    end
    assign evt = (hit[3:0] & ~keyLevel) | rep;
`else
    assign evt = hit[3:0] & ~keyLevel;
`endif

    assign wr_stat   = memWrEn && memAddr == ADDR_KEYSTAT;
    assign clr_s     = wr_stat ? memWrData[3:0] : '0;
    assign clr_o     = wr_stat ? memWrData[7:4] : '0;
    assign unused_wr = ^memWrData[DBITS-1:8];
    // a press coinciding with a clear keeps the sticky bit and is not counted as an overrun
    assign sticky_n  = evt | (sticky & ~clr_s);
    assign ovr_n     = (evt & sticky & ~clr_s) | (ovr & ~clr_o);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            sw_s1    <= '0;
            sw_s2    <= '0;
            for (int k = 0; k < 14; k++) cnt[k] <= '0;
            keyLevel <= '0;
            swLevel  <= '0;
            sticky   <= '0;
            ovr      <= '0;
            keyIrq   <= 1'b0;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            sw_s1    <= SW;
            sw_s2    <= sw_s1;
            for (int k = 0; k < 14; k++) cnt[k] <= din[k] == stab[k] || hit[k] ? '0 : cnt[k] + 1'b1;
            {swLevel, keyLevel} <= stab ^ hit;
            sticky   <= sticky_n;
            ovr      <= ovr_n;
            keyIrq   <= |sticky_n;
        end
    end

    assign rdHit  = memAddr == ADDR_KEY || memAddr == ADDR_SW || memAddr == ADDR_KEYSTAT;
    assign rdData = memAddr == ADDR_KEY     ? DBITS'(keyLevel) :
                    memAddr == ADDR_SW      ? DBITS'(swLevel) :
                    memAddr == ADDR_KEYSTAT ? DBITS'({ovr, sticky}) : '0;
endmodule

// File: tb/tb_key_sw_input_ctrl.sv
// tb_key_sw_input_ctrl: scoreboard bench for key_sw_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_key_sw_input_ctrl;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;
    localparam logic [31:0] A_STAT = 32'hF0000018;
    localparam int S_KEY = 0, S_SW = 1, S_RD = 2, S_HIT = 3, S_IRQ = 4;

    logic clk = 1'b0, reset = 1'b0, memWrEn = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = 10'h3FF;
    logic [31:0] memAddr = A_STAT, memWrData = '0, rdData;
    logic rdHit, keyIrq;
    logic [3:0] keyLevel;
    logic [9:0] swLevel;
    int cyc = 0, n_chk = 0, n_pass = 0;

    typedef struct {string tag; int due; int sel; logic [31:0] exp;} item_t;
    item_t sb[$], keep[$];

    key_sw_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_BITS(4)) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .memAddr(memAddr), .memWrEn(memWrEn),
        .memWrData(memWrData), .rdHit(rdHit), .rdData(rdData), .keyLevel(keyLevel),
        .swLevel(swLevel), .keyIrq(keyIrq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [31:0] obs(input int sel);
        return sel == S_KEY ? 32'(keyLevel) : sel == S_SW ? 32'(swLevel) : sel == S_RD ? rdData :
               sel == S_HIT ? 32'(rdHit) : 32'(keyIrq);
    endfunction

    task automatic want(input string tag, input int sel, input int dly, input logic [31:0] exp);
        sb.push_back('{tag, cyc + dly, sel, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memAddr = addr;
        memWrData = data;
        memWrEn = 1'b1;
        tick(1);
        memWrEn = 1'b0;
        memAddr = A_STAT;
    endtask

    always @(negedge clk) begin
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) check(sb[i].tag, obs(sb[i].sel), sb[i].exp);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    end

    initial begin
        tick(3);
        want("rst_key", S_KEY, 0, 0);
        want("rst_sw", S_SW, 0, 0);
        want("rst_irq", S_IRQ, 0, 0);
        tick(1);
        reset = 1'b1;
        want("sw_lat_early", S_SW, 5, 0);
        want("sw_lat", S_SW, 6, 32'h3FF);
        want("rel_key", S_KEY, 6, 0);
        want("rel_stat", S_RD, 6, 0);
        want("stat_hit", S_HIT, 0, 1);
        tick(8);
        // bounce: 3-cycle low pulse, 1 high, then a long press
        KEY = 4'hE;
        tick(3);
        KEY = 4'hF;
        tick(1);
        KEY = 4'hE;
        want("glitch_key", S_KEY, 5, 0);
        want("glitch_stat", S_RD, 5, 0);
        want("press_key", S_KEY, 6, 1);
        want("press_stat", S_RD, 6, 32'h1);
        want("press_irq", S_IRQ, 6, 1);
        tick(10);
        KEY = 4'hF;
        tick(8);
        want("release_stat", S_RD, 0, 32'h1);
        store(A_STAT, 32'h1);
        want("clr0_stat", S_RD, 0, 0);
        want("clr0_irq", S_IRQ, 0, 0);
        // overrun on KEY[2]
        for (int p = 0; p < 2; p++) begin
            KEY = 4'hB;
            tick(8);
            KEY = 4'hF;
            tick(8);
        end
        want("ovr_stat", S_RD, 0, 32'h44);
        store(A_STAT, 32'h40);
        want("clr_ovr", S_RD, 0, 32'h04);
        store(A_STAT, 32'h04);
        want("clr_all", S_RD, 0, 0);
        want("clr_irq", S_IRQ, 0, 0);
        tick(1);
        // press KEY[1], then second press lands on the same edge as a clear
        KEY = 4'hD;
        tick(8);
        KEY = 4'hF;
        tick(8);
        want("k1_stat", S_RD, 0, 32'h02);
        KEY = 4'hD;
        tick(5);
        store(A_STAT, 32'h02);
        want("simul_stat", S_RD, 0, 32'h02);
        tick(4);
        KEY = 4'hF;
        tick(8);
        store(A_STAT, 32'hFF);
        want("simul_clr", S_RD, 0, 0);
        // decode
        SW = 10'h2A5;
        KEY = 4'h7;
        tick(8);
        memAddr = A_SW;
        want("sw_rd", S_RD, 0, 32'h2A5);
        want("sw_hit", S_HIT, 0, 1);
        tick(1);
        memAddr = 32'hF0000004;
        want("unmap_hit", S_HIT, 0, 0);
        want("unmap_rd", S_RD, 0, 0);
        tick(1);
        memAddr = A_KEY;
        want("key_rd", S_RD, 0, 32'h8);
        want("key_hit", S_HIT, 0, 1);
        tick(1);
        store(A_KEY, 32'hFF);
        want("wr_key_noeff", S_RD, 0, 32'h08);
        tick(1);
        store(32'hF0000004, 32'hFF);
        want("wr_unmap_noeff", S_RD, 0, 32'h08);
        want("wr_irq", S_IRQ, 0, 1);
        KEY = 4'hF;
        tick(8);
        // reset two cycles into a SW[3] debounce
        SW = 10'h2AD;
        tick(4);
        reset = 1'b0;
        want("mid_sw", S_SW, 0, 0);
        want("mid_stat", S_RD, 0, 0);
        want("mid_irq", S_IRQ, 0, 0);
        tick(2);
        reset = 1'b1;
        want("mid_lat_early", S_SW, 5, 0);
        want("mid_lat", S_SW, 6, 32'h2AD);
        tick(10);
        check("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/key_sw_input_ctrl.md
Name: key_sw_input_ctrl

Overview:
- Memory-mapped input conditioning stage sitting directly upstream of the data-memory I/O read path.
- Synchronizes and debounces raw KEY and SW pins.
- Captures key presses in sticky status bits that the CPU reads and clears by store.
- Returns read data for the KEY, SW and KEYSTAT addresses; the data-memory mux selects it when rdHit=1.

Parameters:
- DBITS, 32, data/address width.
- DEBOUNCE_CYCLES, 10000, cycles an input must hold a new value before the stable value updates; minimum 2.
- CNT_BITS, 16, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.
- ADDR_KEY, 32'hF0000010, stable key level register, read-only.
- ADDR_SW, 32'hF0000014, stable switch level register, read-only.
- ADDR_KEYSTAT, 32'hF0000018, sticky press/overrun register, write-1-to-clear.

Ports:
- clk  in  1  system clock (PLL c0)
- reset  in  1  asynchronous, active-low reset
- KEY  in  4  raw push buttons, active-low at pin (0 = pressed)
- SW  in  10  raw slide switches, active-high
- memAddr  in  DBITS  CPU data address (ALU result)
- memWrEn  in  1  CPU store strobe, sampled on clk rising edge
- memWrData  in  DBITS  CPU store data
- rdHit  out  1  memAddr decodes to one of the three addresses
- rdData  out  DBITS  read data; 0 when rdHit=0
- keyLevel  out  4  debounced key state, 1 = pressed
- swLevel  out  10  debounced switch state
- keyIrq  out  1  OR of the four sticky press bits

Behaviour:
- Reset (reset=0, asynchronous): clears all state.
  - Synchronizers load the released values: KEY sync = 4'hF, SW sync = 0.
  - Debounce counters = 0; keyLevel = 0; swLevel = 0.
  - Sticky press bits = 0; overrun bits = 0; keyIrq = 0.
  - Reset mid-debounce discards the partial count.
- Synchronizer: two flops per bit. Keys are inverted after synchronization, so 1 = pressed internally.
- Debounce, per bit, independent counter:
  - If sync value == stable value: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync value, counter <= 0.
  - Else: counter <= counter + 1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches the stable value.
- Latency: a clean raw change appears on keyLevel/swLevel exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
- Press event: keyLevel[i] 0->1 transition, one cycle. Release causes no event.
  - Sets sticky[i].
  - If sticky[i] was already 1 and is not being cleared this cycle, also sets ovr[i].
- Read decode (combinational):
  - ADDR_KEY: {28'b0, keyLevel}
  - ADDR_SW: {22'b0, swLevel}
  - ADDR_KEYSTAT: {24'b0, ovr[3:0], sticky[3:0]}
  - rdHit = 1 for these three addresses only; otherwise rdHit = 0 and rdData = 0.
- Write to ADDR_KEYSTAT with memWrEn=1: bit k of memWrData[7:0] = 1 clears status bit k; bits [31:8] are ignored.
- Press event and clear on the same bit in the same cycle: the set wins (sticky stays 1, ovr not set, no event lost).
- Writes to ADDR_KEY, ADDR_SW or unmapped addresses have no effect.
- keyIrq = |sticky, driven from flops, no combinational path from the pins.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Adds parameter REPEAT_CYCLES (default 5000000) and one repeat counter per key.
  - While keyLevel[i] is held at 1, a further press event is generated every REPEAT_CYCLES cycles, counted from the initial press.
  - The counter resets on release and on reset.
  - Repeat events set sticky[i] and ovr[i] with the same rules as a real press.
- Undefined: exactly one event per debounced press; no repeat counters are built.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 with KEY=4'hF, SW=10'h3FF, then release -> keyLevel=0; swLevel becomes 10'h3FF exactly 6 edges later; KEYSTAT reads 0.
- Bounce: KEY[0] low 3 cycles, high 1, low 10 -> no event from the 3-cycle pulse; keyLevel[0]=1 six edges after the final fall; sticky[0]=1; keyIrq=1; memAddr=ADDR_KEYSTAT reads 32'h1.
- Overrun: two clean presses of KEY[2] with no clear between -> KEYSTAT = 32'h44.
  - Store 32'h40 -> KEYSTAT reads 32'h04.
  - Store 32'h04 -> KEYSTAT reads 0; keyIrq=0.
- Simultaneous: press event on KEY[1] in the same cycle as a store of 32'h02 to ADDR_KEYSTAT -> next cycle sticky[1]=1, ovr[1]=0.
- Decode: memAddr=ADDR_SW with SW stable 10'h2A5 -> rdData=32'h2A5, rdHit=1.
  - memAddr=32'hF0000004 -> rdHit=0, rdData=0.
  - Store to ADDR_KEY -> no state change.
- Reset mid-operation: assert reset 2 cycles into a 4-cycle debounce of SW[3] -> swLevel[3]=0 immediately; after release, the full 6-edge latency applies again.
